csr_file: RTL and testbench

- Machine-mode CSR storage and counter block; the responder on the decode stage's CSR interface (`csr_addr`, `csr_wdata`, `csr_wb` in; `csr_rdata` out).
- Returns CSR read data combinationally in the same cycle, so decode can form read-modify-write data.
- Commits writes on the clock edge.
- Runs the mcycle/minstret counters and the trap/mret side effects on mstatus/mcause.
- Drives the `mtvec` and `mepc` values used by the fetch PC mux.

---
 rtl/csr_file.sv | 128 ++++++++++++
 tb/tb_csr_file.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read mux, edge-committed writes, mcycle/minstret
// counters and trap/mret side effects on mstatus/mcause.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_wb,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_enter,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  input  logic        instret_inc,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [11:0] addr;
  logic        addr_hi_ok;
  logic        mapped, read_only;
  logic [31:0] rd_mux;
  logic [31:0] mstatus_rd;
  logic        wen;

  assign addr       = csr_addr[11:0];
  assign addr_hi_ok = (csr_addr[31:12] == 20'd0);
  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

  always_comb begin
    rd_mux    = 32'd0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (addr)
      12'h300: rd_mux = mstatus_rd;
      12'h305: rd_mux = mtvec_q;
      12'h340: rd_mux = mscratch_q;
      12'h341: rd_mux = mepc_q;
      12'h342: rd_mux = mcause_q;
      12'hB00: rd_mux = mcycle_q[31:0];
      12'hB80: rd_mux = mcycle_q[63:32];
      12'hB02: rd_mux = minstret_q[31:0];
      12'hB82: rd_mux = minstret_q[63:32];
      12'hC00: begin rd_mux = mcycle_q[31:0];     read_only = 1'b1; end
      12'hC80: begin rd_mux = mcycle_q[63:32];    read_only = 1'b1; end
      12'hC02: begin rd_mux = minstret_q[31:0];   read_only = 1'b1; end
      12'hC82: begin rd_mux = minstret_q[63:32];  read_only = 1'b1; end
      12'hF14: begin rd_mux = HART_ID;            read_only = 1'b1; end
      default: mapped = 1'b0;
    endcase
    // Upper address bits set (including decode's "no CSR" code) mean unmapped
    if (!addr_hi_ok) begin
      mapped    = 1'b0;
      read_only = 1'b0;
    end
  end

  assign csr_rdata   = mapped ? rd_mux : 32'd0;
  assign csr_illegal = !mapped || (csr_wb && read_only);
  assign wen         = csr_wb && mapped && !read_only;

  logic w_mstatus, w_mtvec, w_mscratch, w_mepc, w_mcause;
  logic w_mcycle_lo, w_mcycle_hi, w_minstret_lo, w_minstret_hi;

  assign w_mstatus     = wen && (addr == 12'h300);
  assign w_mtvec       = wen && (addr == 12'h305);
  assign w_mscratch    = wen && (addr == 12'h340);
  assign w_mepc        = wen && (addr == 12'h341);
  assign w_mcause      = wen && (addr == 12'h342);
  assign w_mcycle_lo   = wen && (addr == 12'hB00);
  assign w_mcycle_hi   = wen && (addr == 12'hB80);
  assign w_minstret_lo = wen && (addr == 12'hB02);
  assign w_minstret_hi = wen && (addr == 12'hB82);

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~32'd3;
      mscratch_q <= 32'd0;
      mepc_q     <= 32'd0;
      mcause_q   <= 32'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      // Priority: trap over mret over a software write of mstatus
      if (trap_enter) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (mret) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (w_mstatus) begin
        mie_q  <= csr_wdata[3];
        mpie_q <= csr_wdata[7];
      end

      if (trap_enter)    mcause_q <= trap_cause;
      else if (w_mcause) mcause_q <= csr_wdata;

      if (w_mtvec)    mtvec_q    <= {csr_wdata[31:2], 2'b00};
      if (w_mscratch) mscratch_q <= csr_wdata;
      if (w_mepc)     mepc_q     <= {csr_wdata[31:2], 2'b00};

      // A write to either half suppresses that cycle's increment
      if (w_mcycle_lo)      mcycle_q[31:0]  <= csr_wdata;
      else if (w_mcycle_hi) mcycle_q[63:32] <= csr_wdata;
      else                  mcycle_q        <= mcycle_q + 64'd1;

      if (w_minstret_lo)      minstret_q[31:0]  <= csr_wdata;
      else if (w_minstret_hi) minstret_q[63:32] <= csr_wdata;
      else if (instret_inc)   minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;
  assign mie_out   = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: one task per feature, inline comparisons against hand-computed values.
module tb_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] HARTID    = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] csr_addr, csr_wdata, trap_cause;
  logic        csr_wb, trap_enter, mret, instret_inc;
  logic [31:0] csr_rdata, mtvec_out, mepc_out;
  logic        csr_illegal, mie_out;

  int vecs = 0;
  int errs = 0;

  csr_file #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HARTID)) dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wb(csr_wb),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_enter(trap_enter),
    .trap_cause(trap_cause), .mret(mret), .instret_inc(instret_inc),
    .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_out(mie_out)
  );

  always #20 clk = ~clk;

  localparam logic [31:0] RST_ADDR [14] = '{32'h300, 32'h305, 32'h340, 32'h341, 32'h342,
    32'hB00, 32'hB80, 32'hB02, 32'hB82, 32'hC00, 32'hC80, 32'hC02, 32'hC82, 32'hF14};
  localparam logic [31:0] RST_EXP [14] = '{32'h0000_1800, 32'h0000_1000, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0005};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    csr_addr = a;
    #1;
  endtask

  task automatic idle();
    csr_wb = 1'b0; trap_enter = 1'b0; mret = 1'b0; instret_inc = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      rd(RST_ADDR[i]);
      vecs++; if (csr_rdata !== RST_EXP[i]) begin errs++; $display("FAIL reset_rd addr=%h got %h exp %h", RST_ADDR[i], csr_rdata, RST_EXP[i]); end
      vecs++; if (csr_illegal !== 1'b0) begin errs++; $display("FAIL reset_illegal addr=%h got %b exp 0", RST_ADDR[i], csr_illegal); end
    end
    vecs++; if (mtvec_out !== 32'h1000) begin errs++; $display("FAIL reset_mtvec_out got %h exp 00001000", mtvec_out); end
    vecs++; if (mepc_out !== 32'h0) begin errs++; $display("FAIL reset_mepc_out got %h exp 0", mepc_out); end
    vecs++; if (mie_out !== 1'b0) begin errs++; $display("FAIL reset_mie_out got %b exp 0", mie_out); end
    tick();
    rd(32'hC00);
    vecs++; if (csr_rdata !== 32'd1) begin errs++; $display("FAIL reset_cycle_second got %h exp 1", csr_rdata); end
    rd(32'hC02);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL reset_instret_hold got %h exp 0", csr_rdata); end
  endtask

  task automatic test_writes();
    csr_addr = 32'h305; csr_wdata = 32'h8000_0103; csr_wb = 1'b1;
    #1;
    vecs++; if (csr_illegal !== 1'b0) begin errs++; $display("FAIL mtvec_wr_illegal got %b exp 0", csr_illegal); end
    vecs++; if (mtvec_out !== 32'h1000) begin errs++; $display("FAIL mtvec_not_early got %h exp 00001000", mtvec_out); end
    tick();
    csr_wb = 1'b0;
    rd(32'h305);
    vecs++; if (csr_rdata !== 32'h8000_0100) begin errs++; $display("FAIL mtvec_rd got %h exp 80000100", csr_rdata); end
    vecs++; if (mtvec_out !== 32'h8000_0100) begin errs++; $display("FAIL mtvec_out got %h exp 80000100", mtvec_out); end
    csr_addr = 32'h300; csr_wdata = 32'hFFFF_FFFF; csr_wb = 1'b1;
    tick();
    csr_wb = 1'b0;
    rd(32'h300);
    vecs++; if (csr_rdata !== 32'h0000_1888) begin errs++; $display("FAIL mstatus_mask got %h exp 00001888", csr_rdata); end
    vecs++; if (mie_out !== 1'b1) begin errs++; $display("FAIL mstatus_mie_out got %b exp 1", mie_out); end
  endtask

  task automatic test_back_to_back();
    csr_addr = 32'h340; csr_wdata = 32'hA5A5_A5A5; csr_wb = 1'b1;
    tick();
    csr_wdata = 32'h5A5A_5A5A;
    #1;
    vecs++; if (csr_rdata !== 32'hA5A5_A5A5) begin errs++; $display("FAIL b2b_first got %h exp a5a5a5a5", csr_rdata); end
    tick();
    csr_wb = 1'b0;
    #1;
    vecs++; if (csr_rdata !== 32'h5A5A_5A5A) begin errs++; $display("FAIL b2b_second got %h exp 5a5a5a5a", csr_rdata); end
  endtask

  task automatic test_mcycle();
    csr_addr = 32'hB00; csr_wdata = 32'hFFFF_FFFE; csr_wb = 1'b1;
    tick();
    csr_addr = 32'hB80; csr_wdata = 32'h0;
    tick();
    csr_wb = 1'b0;
    rd(32'hB00);
    vecs++; if (csr_rdata !== 32'hFFFF_FFFE) begin errs++; $display("FAIL mcycle_hold_on_hi_wr got %h exp fffffffe", csr_rdata); end
    tick(); tick();
    rd(32'hC80);
    vecs++; if (csr_rdata !== 32'd1) begin errs++; $display("FAIL mcycle_carry_hi got %h exp 1", csr_rdata); end
    rd(32'hC00);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL mcycle_carry_lo got %h exp 0", csr_rdata); end
    tick();
    csr_addr = 32'hB80; csr_wdata = 32'd7; csr_wb = 1'b1;
    tick();
    csr_wb = 1'b0;
    rd(32'hB00);
    vecs++; if (csr_rdata !== 32'd1) begin errs++; $display("FAIL mcycle_no_inc_on_wr got %h exp 1", csr_rdata); end
    rd(32'hB80);
    vecs++; if (csr_rdata !== 32'd7) begin errs++; $display("FAIL mcycle_hi_wr got %h exp 7", csr_rdata); end
    tick();
    rd(32'hC00);
    vecs++; if (csr_rdata !== 32'd2) begin errs++; $display("FAIL mcycle_resume got %h exp 2", csr_rdata); end
  endtask

  task automatic test_minstret();
    instret_inc = 1'b1;
    csr_addr = 32'hB02; csr_wdata = 32'd5; csr_wb = 1'b1;
    tick();
    csr_wb = 1'b0;
    rd(32'hC02);
    vecs++; if (csr_rdata !== 32'd5) begin errs++; $display("FAIL minstret_wr_wins got %h exp 5", csr_rdata); end
    tick(); tick();
    instret_inc = 1'b0;
    tick();
    rd(32'hC02);
    vecs++; if (csr_rdata !== 32'd7) begin errs++; $display("FAIL minstret_count got %h exp 7", csr_rdata); end
    csr_addr = 32'hB02; csr_wdata = 32'hFFFF_FFFF; csr_wb = 1'b1;
    tick();
    csr_wb = 1'b0; instret_inc = 1'b1;
    tick();
    instret_inc = 1'b0;
    rd(32'hC02);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL minstret_wrap_lo got %h exp 0", csr_rdata); end
    rd(32'hC82);
    vecs++; if (csr_rdata !== 32'd1) begin errs++; $display("FAIL minstret_carry_hi got %h exp 1", csr_rdata); end
    instret_inc = 1'b1;
    csr_addr = 32'hB82; csr_wdata = 32'd9; csr_wb = 1'b1;
    tick();
    csr_wb = 1'b0; instret_inc = 1'b0;
    rd(32'hB02);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL minstret_hi_wr_no_inc got %h exp 0", csr_rdata); end
    rd(32'hB82);
    vecs++; if (csr_rdata !== 32'd9) begin errs++; $display("FAIL minstret_hi_wr got %h exp 9", csr_rdata); end
  endtask

  task automatic test_trap();
    csr_addr = 32'h300; csr_wdata = 32'h0000_0008; csr_wb = 1'b1;
    tick();
    trap_enter = 1'b1; trap_cause = 32'd11;
    csr_addr = 32'h341; csr_wdata = 32'h0000_0040; csr_wb = 1'b1;
    tick();
    idle();
    rd(32'h342);
    vecs++; if (csr_rdata !== 32'd11) begin errs++; $display("FAIL trap_mcause got %h exp b", csr_rdata); end
    rd(32'h300);
    vecs++; if (csr_rdata !== 32'h0000_1880) begin errs++; $display("FAIL trap_mstatus got %h exp 00001880", csr_rdata); end
    vecs++; if (mie_out !== 1'b0) begin errs++; $display("FAIL trap_mie_out got %b exp 0", mie_out); end
    vecs++; if (mepc_out !== 32'h40) begin errs++; $display("FAIL trap_mepc got %h exp 40", mepc_out); end
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd(32'h300);
    vecs++; if (csr_rdata !== 32'h0000_1888) begin errs++; $display("FAIL mret_mstatus got %h exp 00001888", csr_rdata); end
    vecs++; if (mie_out !== 1'b1) begin errs++; $display("FAIL mret_mie_out got %b exp 1", mie_out); end
    trap_enter = 1'b1; trap_cause = 32'd2;
    csr_addr = 32'h342; csr_wdata = 32'h0000_DEAD; csr_wb = 1'b1;
    tick();
    idle();
    rd(32'h342);
    vecs++; if (csr_rdata !== 32'd2) begin errs++; $display("FAIL trap_beats_mcause_wr got %h exp 2", csr_rdata); end
    mret = 1'b1;
    csr_addr = 32'h300; csr_wdata = 32'h0; csr_wb = 1'b1;
    tick();
    idle();
    rd(32'h300);
    vecs++; if (csr_rdata !== 32'h0000_1888) begin errs++; $display("FAIL mret_beats_mstatus_wr got %h exp 00001888", csr_rdata); end
    csr_addr = 32'h341; csr_wdata = 32'h0000_0123; csr_wb = 1'b1;
    tick();
    csr_wb = 1'b0;
    #1;
    vecs++; if (mepc_out !== 32'h0000_0120) begin errs++; $display("FAIL mepc_mask got %h exp 00000120", mepc_out); end
    trap_enter = 1'b1; mret = 1'b1; trap_cause = 32'd3;
    tick();
    idle();
    rd(32'h300);
    vecs++; if (csr_rdata !== 32'h0000_1880) begin errs++; $display("FAIL trap_and_mret got %h exp 00001880", csr_rdata); end
    rd(32'h342);
    vecs++; if (csr_rdata !== 32'd3) begin errs++; $display("FAIL trap_and_mret_cause got %h exp 3", csr_rdata); end
  endtask

  task automatic test_illegal();
    csr_addr = 32'hB00; csr_wdata = 32'd100; csr_wb = 1'b1;
    tick();
    csr_addr = 32'hC00; csr_wdata = 32'd0;
    #1;
    vecs++; if (csr_illegal !== 1'b1) begin errs++; $display("FAIL ro_wr_illegal got %b exp 1", csr_illegal); end
    tick();
    csr_wb = 1'b0;
    #1;
    vecs++; if (csr_rdata !== 32'd101) begin errs++; $display("FAIL ro_wr_ignored got %h exp 65", csr_rdata); end
    vecs++; if (csr_illegal !== 1'b0) begin errs++; $display("FAIL ro_rd_legal got %b exp 0", csr_illegal); end
    csr_addr = 32'hF14; csr_wb = 1'b1;
    #1;
    vecs++; if (csr_illegal !== 1'b1) begin errs++; $display("FAIL hartid_wr_illegal got %b exp 1", csr_illegal); end
    csr_wb = 1'b0;
    #1;
    vecs++; if (csr_illegal !== 1'b0 || csr_rdata !== HARTID) begin errs++; $display("FAIL hartid_rd got %b/%h exp 0/%h", csr_illegal, csr_rdata, HARTID); end
    rd(32'h7C0);
    vecs++; if (csr_rdata !== 32'd0 || csr_illegal !== 1'b1) begin errs++; $display("FAIL unmapped_7c0 got %h/%b exp 0/1", csr_rdata, csr_illegal); end
    rd(32'h0000_1300);
    vecs++; if (csr_rdata !== 32'd0 || csr_illegal !== 1'b1) begin errs++; $display("FAIL unmapped_hi_bits got %h/%b exp 0/1", csr_rdata, csr_illegal); end
  endtask

  task automatic test_reset_mid();
    csr_addr = 32'h340; csr_wdata = 32'h0000_1234; csr_wb = 1'b1;
    tick();
    rst = 1'b1; trap_enter = 1'b1; trap_cause = 32'd5; instret_inc = 1'b1;
    csr_wdata = 32'h0000_FFFF;
    tick();
    idle();
    rd(32'h340);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL rstmid_mscratch got %h exp 0", csr_rdata); end
    rd(32'h342);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL rstmid_mcause got %h exp 0", csr_rdata); end
    rd(32'h300);
    vecs++; if (csr_rdata !== 32'h0000_1800) begin errs++; $display("FAIL rstmid_mstatus got %h exp 00001800", csr_rdata); end
    rd(32'hC00);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL rstmid_cycle got %h exp 0", csr_rdata); end
    rd(32'hC80);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL rstmid_cycleh got %h exp 0", csr_rdata); end
    rd(32'hC82);
    vecs++; if (csr_rdata !== 32'd0) begin errs++; $display("FAIL rstmid_instreth got %h exp 0", csr_rdata); end
    vecs++; if (mtvec_out !== 32'h1000 || mepc_out !== 32'd0) begin errs++; $display("FAIL rstmid_outs got %h/%h exp 00001000/0", mtvec_out, mepc_out); end
  endtask

  initial begin
    csr_addr = 32'd0; csr_wdata = 32'd0; trap_cause = 32'd0;
    csr_wb = 1'b0; trap_enter = 1'b0; mret = 1'b0; instret_inc = 1'b0; rst = 1'b1;
    test_reset();
    test_writes();
    test_back_to_back();
    test_mcycle();
    test_minstret();
    test_trap();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
